// File: rtl/hazard_pkg.sv
// Shared constants and width helpers for the hazard scoreboard.
package hazard_pkg;

  localparam int FWD_RF         = 0;
  localparam int NREGS_DEF      = 32;
  localparam int FWD_STAGES_DEF = 2;
  localparam int MAX_LAT_DEF    = 8;
  localparam int BR_SLOTS_DEF   = 1;

  // Bits needed to hold 0..maxval, never less than one.
  function automatic int width_for(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

  function automatic int fwd_width(input int stages);
    return width_for(stages);
  endfunction

endpackage

// File: rtl/hsb_entry.sv
// One register's write-pending countdown with its forwarding-path decode.
module hsb_entry
  import hazard_pkg::*;
#(
  parameter int LW         = 4,
  parameter int FW         = 2,
  parameter int FWD_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [LW-1:0] lat,
  output logic [LW-1:0] cnt,
  output logic          pending,
  output logic          ready,
  output logic [FW-1:0] fwd
);

  // A new write overrides the running countdown of an older one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= lat;
    end else if (cnt != '0) begin
      cnt <= cnt - LW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign pending = (cnt != '0);
  assign ready   = (cnt <= LW'(FWD_STAGES));
  assign fwd     = ready ? FW'(cnt) : FW'(FWD_RF);

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue scoreboard: RAW/WAW stalls, forwarding selects, branch squash.
// Optional write-port slot check enabled by defining HSB_WBPORT_CHECK_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS      = NREGS_DEF,
  parameter int FWD_STAGES = FWD_STAGES_DEF,
  parameter int MAX_LAT    = MAX_LAT_DEF,
  parameter int BR_SLOTS   = BR_SLOTS_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               issue_valid,
  input  logic [$clog2(NREGS)-1:0]           rs,
  input  logic [$clog2(NREGS)-1:0]           rt,
  input  logic                               rs_used,
  input  logic                               rt_used,
  input  logic [$clog2(NREGS)-1:0]           rd,
  input  logic                               wreg,
  input  logic [$clog2(MAX_LAT+1)-1:0]       lat,
  input  logic                               branch_taken,
  output logic [fwd_width(FWD_STAGES)-1:0]   fwda,
  output logic [fwd_width(FWD_STAGES)-1:0]   fwdb,
  output logic                               stall,
  output logic                               fire,
  output logic                               squash,
  output logic                               busy
);

  localparam int RW = $clog2(NREGS);
  localparam int LW = $clog2(MAX_LAT + 1);
  localparam int FW = fwd_width(FWD_STAGES);
  localparam int SW = width_for(BR_SLOTS);

  logic [LW-1:0]    cnt_tab   [NREGS];
  logic [FW-1:0]    fwd_tab   [NREGS];
  logic [NREGS-1:0] ready_tab;
  logic [NREGS-1:0] pend;
  logic [SW-1:0]    sq_cnt;
  logic             rs_hit, rt_hit, wr_en, raw, waw, wbport;

  // Register 0 never has a pending write.
  assign cnt_tab[0]   = '0;
  assign fwd_tab[0]   = FW'(FWD_RF);
  assign ready_tab[0] = 1'b1;
  assign pend[0]      = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_entry
    hsb_entry #(
      .LW         (LW),
      .FW         (FW),
      .FWD_STAGES (FWD_STAGES)
    ) u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (fire & wr_en & (rd == RW'(r))),
      .lat     (lat),
      .cnt     (cnt_tab[r]),
      .pending (pend[r]),
      .ready   (ready_tab[r]),
      .fwd     (fwd_tab[r])
    );
  end

  assign rs_hit = rs_used & (rs != '0);
  assign rt_hit = rt_used & (rt != '0);
  assign wr_en  = wreg & (rd != '0);
  assign raw    = (rs_hit & ~ready_tab[rs]) | (rt_hit & ~ready_tab[rt]);
  assign waw    = wr_en & (cnt_tab[rd] >= lat);

`ifdef HSB_WBPORT_CHECK_EN
  // slot[k] set means some write retires when its countdown reads k+1.
  logic [MAX_LAT-1:0] slot, slot_shift, slot_new;

  assign slot_shift = slot >> 1;
  assign slot_new   = MAX_LAT'(1) << (lat - LW'(1));
  assign wbport     = wr_en & (|(slot_shift & slot_new));

  // Shift the reservation window and claim the new instruction's slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (fire & wr_en) begin
      slot <= slot_shift | slot_new;
    end else begin
      slot <= slot_shift;
    end
  end
`else
  assign wbport = 1'b0;
`endif

  // Squash window: reload on every taken branch, consume only on decode cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sq_cnt <= '0;
    end else if (branch_taken) begin
      sq_cnt <= SW'(BR_SLOTS);
    end else if (issue_valid && (sq_cnt != '0)) begin
      sq_cnt <= sq_cnt - SW'(1);
    end else begin
      sq_cnt <= sq_cnt;
    end
  end

  // Issue decision and forwarding selects, all forced quiet during reset.
  always_comb begin
    stall  = 1'b0;
    fire   = 1'b0;
    squash = 1'b0;
    busy   = 1'b0;
    fwda   = FW'(FWD_RF);
    fwdb   = FW'(FWD_RF);
    if (rst_n) begin
      squash = issue_valid & (sq_cnt != '0);
      stall  = issue_valid & ~squash & (raw | waw | wbport);
      fire   = issue_valid & ~stall & ~squash;
      busy   = |pend;
      fwda   = rs_hit ? fwd_tab[rs] : FW'(FWD_RF);
      fwdb   = rt_hit ? fwd_tab[rt] : FW'(FWD_RF);
    end else begin
      stall  = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with a queue-based output checker.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid = 1'b0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic       rs_used = 1'b0, rt_used = 1'b0, wreg = 1'b0, branch_taken = 1'b0;
  logic [3:0] lat = '0;
  logic [1:0] fwda, fwdb;
  logic       stall, fire, squash, busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      nm;
    logic       st, fi, sq, cf, bz;
    logic [1:0] fa, fb;
  } exp_t;

  exp_t exp_q[$];

  hazard_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .rs           (rs),
    .rt           (rt),
    .rs_used      (rs_used),
    .rt_used      (rt_used),
    .rd           (rd),
    .wreg         (wreg),
    .lat          (lat),
    .branch_taken (branch_taken),
    .fwda         (fwda),
    .fwdb         (fwdb),
    .stall        (stall),
    .fire         (fire),
    .squash       (squash),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string f, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, f, act, exp);
    end
  endtask

  // Monitor: every cycle with an outstanding vector, compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "stall",  int'(stall),  int'(e.st));
        chk(e.nm, "fire",   int'(fire),   int'(e.fi));
        chk(e.nm, "squash", int'(squash), int'(e.sq));
        chk(e.nm, "busy",   int'(busy),   int'(e.bz));
        if (e.cf) begin
          chk(e.nm, "fwda", int'(fwda), int'(e.fa));
          chk(e.nm, "fwdb", int'(fwdb), int'(e.fb));
        end
      end
    end
  end

  // Apply one cycle of inputs and queue the hand-computed response.
  task automatic vec(input string nm, input logic v_rst, input logic v_iv,
                     input int v_rs, input logic v_rsu, input int v_rt, input logic v_rtu,
                     input int v_rd, input logic v_w, input int v_lat, input logic v_br,
                     input logic e_st, input logic e_fi, input logic e_sq,
                     input int e_fa, input int e_fb, input logic e_cf, input logic e_bz);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = v_rst;
    issue_valid  = v_iv;
    rs           = 5'(v_rs);
    rs_used      = v_rsu;
    rt           = 5'(v_rt);
    rt_used      = v_rtu;
    rd           = 5'(v_rd);
    wreg         = v_w;
    lat          = 4'(v_lat);
    branch_taken = v_br;
    e.nm = nm; e.st = e_st; e.fi = e_fi; e.sq = e_sq;
    e.fa = 2'(e_fa); e.fb = 2'(e_fb); e.cf = e_cf; e.bz = e_bz;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic e_bz);
    vec(nm, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0,
        1'b0, 1'b0, 1'b0, 0, 0, 1'b1, e_bz);
  endtask

  initial begin
    int waited;
    //   name         rst iv  rs rsu rt rtu rd w lat br   st fi sq fa fb cf busy
    vec("rst0",       0,  1,  1, 1,  0, 0,  2, 1, 3, 0,   0, 0, 0, 0, 0, 1, 0);
    vec("rst1",       0,  1,  1, 1,  0, 0,  2, 1, 3, 1,   0, 0, 0, 0, 0, 1, 0);
    vec("raw_w5",     1,  1,  0, 0,  0, 0,  5, 1, 2, 0,   0, 1, 0, 0, 0, 1, 0);
    vec("raw_f2",     1,  1,  5, 1,  0, 0,  0, 0, 0, 0,   0, 1, 0, 2, 0, 1, 1);
    vec("raw_f1",     1,  1,  5, 1,  0, 0,  0, 0, 0, 0,   0, 1, 0, 1, 0, 1, 1);
    vec("raw_rf",     1,  1,  5, 1,  0, 0,  0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 0);
    vec("ld_w8",      1,  1,  0, 0,  0, 0,  8, 1, 3, 0,   0, 1, 0, 0, 0, 1, 0);
    vec("ld_stall",   1,  1,  0, 0,  8, 1,  0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
    vec("ld_fire",    1,  1,  0, 0,  8, 1,  0, 0, 0, 0,   0, 1, 0, 0, 2, 1, 1);
    idle("ld_drain", 1'b1);
    vec("waw_w3",     1,  1,  0, 0,  0, 0,  3, 1, 6, 0,   0, 1, 0, 0, 0, 1, 0);
    idle("waw_gap", 1'b1);
    for (int i = 0; i < 4; i++)
      vec("waw_stall", 1, 1,  0, 0,  0, 0,  3, 1, 2, 0,   1, 0, 0, 0, 0, 1, 1);
    vec("waw_fire",   1,  1,  0, 0,  0, 0,  3, 1, 2, 0,   0, 1, 0, 0, 0, 1, 1);
    idle("waw_d1", 1'b1);
    idle("waw_d2", 1'b1);
    vec("br_issue",   1,  1,  0, 0,  0, 0, 10, 1, 1, 1,   0, 1, 0, 0, 0, 1, 0);
    vec("br_squash",  1,  1,  0, 0,  0, 0, 11, 1, 4, 0,   0, 0, 1, 0, 0, 1, 1);
    vec("br_next",    1,  1, 11, 1,  0, 0,  0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 0);
    vec("br_idle",    1,  0,  0, 0,  0, 0,  0, 0, 0, 1,   0, 0, 0, 0, 0, 1, 0);
    idle("sq_hold", 1'b0);
    vec("sq_kill",    1,  1,  0, 0,  0, 0,  0, 0, 0, 0,   0, 0, 1, 0, 0, 1, 0);
    vec("sq_done",    1,  1,  0, 0,  0, 0,  0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 0);
    vec("r0_w",       1,  1,  0, 0,  0, 0,  0, 1, 4, 0,   0, 1, 0, 0, 0, 1, 0);
    vec("r0_rd",      1,  1,  0, 1,  0, 0,  0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 0);
    vec("unused_w",   1,  1,  0, 0,  0, 0, 12, 1, 2, 0,   0, 1, 0, 0, 0, 1, 0);
    vec("unused_rd",  1,  1, 12, 0, 12, 0,  0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 1);
    vec("wb_first",   1,  1,  0, 0,  0, 0, 13, 1, 4, 0,   0, 1, 0, 0, 0, 1, 1);
`ifdef HSB_WBPORT_CHECK_EN
    vec("wb_clash",   1,  1,  0, 0,  0, 0, 14, 1, 3, 0,   1, 0, 0, 0, 0, 1, 1);
    vec("wb_retry",   1,  1,  0, 0,  0, 0, 14, 1, 3, 0,   0, 1, 0, 0, 0, 1, 1);
`else
    vec("wb_clash",   1,  1,  0, 0,  0, 0, 14, 1, 3, 0,   0, 1, 0, 0, 0, 1, 1);
    idle("wb_idle", 1'b1);
`endif
    vec("rst_mid_w",  1,  1,  0, 0,  0, 0,  7, 1, 8, 0,   0, 1, 0, 0, 0, 1, 1);
    vec("rst_mid",    0,  1, 13, 1,  0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);
    vec("rst_after",  1,  1,  7, 1,  0, 0,  0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 0);
    idle("tail", 1'b0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending vectors, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
